hazard_scoreboard: RTL

// Consumer end of the ID->EXE pipeline register: takes its registered dest/control/source-id outputs plus ID-stage sources.

---
 rtl/ca_pkg.sv | 14 +
 rtl/sat_counter.sv | 35 +++
 rtl/hazard_scoreboard.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ca_pkg.sv
// Shared constants and types for the ID/EXE hazard scoreboard: forwarding
// select encodings and the branch-flush FSM state type.
package ca_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard at the consumer side of ID->EXE: IF/ID freeze on RAW hazards,
// branch flush sequencing, EXE operand forwarding selects and perf counters.
module hazard_scoreboard
    import ca_pkg::*;
#(
    parameter bit          FORWARD_EN = 1'b1,
    parameter int unsigned FLUSH_LEN  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic             exe_branch_taken,
    input  logic             cnt_clr,
    output logic             freeze,
    output logic             flush,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned FLUSH_EXTRA    = (FLUSH_LEN > 1) ? FLUSH_LEN - 2 : 0;
    localparam logic [1:0]  FLUSH_CNT_INIT = 2'(FLUSH_EXTRA);

    // Enable is evaluated first so an undriven dest behind wb_en=0 never matches.
    function automatic logic hit(input logic [3:0] s, input logic [3:0] d, input logic en);
        return en && (s == d);
    endfunction

    function automatic logic [1:0] fwd_pick(
        input logic [3:0] src,
        input logic [3:0] m_dest,
        input logic       m_fwd_ok,
        input logic [3:0] w_dest,
        input logic       w_en
    );
        if (hit(src, m_dest, m_fwd_ok)) begin
            return FWD_MEM;
        end else if (hit(src, w_dest, w_en)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    logic       mem_wb_q, mem_wb_d;
    logic       mem_rd_q, mem_rd_d;
    logic [3:0] mem_dest_q, mem_dest_d;
    logic       wb_wb_q, wb_wb_d;
    logic [3:0] wb_dest_q, wb_dest_d;

    state_t     state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;

    logic       exe_raw;
    logic       mem_raw;
    logic       freeze_raw;
    logic       flush_raw;
    logic       branch_accept;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // MEM/WB tracking advances every cycle; a freeze only holds IF/ID.
    always_comb begin
        mem_wb_d   = exe_wb_en;
        mem_rd_d   = exe_mem_r_en;
        mem_dest_d = exe_dest;
        wb_wb_d    = mem_wb_q;
        wb_dest_d  = mem_dest_q;
    end

    always_comb begin
        exe_raw = hit(id_src1, exe_dest, exe_wb_en)
                | (id_two_src & hit(id_src2, exe_dest, exe_wb_en));
        mem_raw = hit(id_src1, mem_dest_q, mem_wb_q)
                | (id_two_src & hit(id_src2, mem_dest_q, mem_wb_q));
        if (FORWARD_EN) begin
            freeze_raw = id_valid & exe_mem_r_en & exe_raw;
        end else begin
            freeze_raw = id_valid & (exe_raw | mem_raw);
        end
    end

    always_comb begin
        fwd_a_raw = fwd_pick(exe_src1, mem_dest_q, mem_wb_q & ~mem_rd_q, wb_dest_q, wb_wb_q);
        fwd_b_raw = fwd_pick(exe_src2, mem_dest_q, mem_wb_q & ~mem_rd_q, wb_dest_q, wb_wb_q);
    end

    // Taken branches seen while already flushing are dropped and not counted.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        flush_raw     = 1'b0;
        branch_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exe_branch_taken) begin
                    flush_raw     = 1'b1;
                    branch_accept = 1'b1;
                    if (FLUSH_LEN > 1) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_CNT_INIT;
                    end
                end
            end
            ST_FLUSH: begin
                flush_raw = 1'b1;
                if (fcnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_dest_q <= '0;
            wb_wb_q    <= 1'b0;
            wb_dest_q  <= '0;
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
        end else begin
            mem_wb_q   <= mem_wb_d;
            mem_rd_q   <= mem_rd_d;
            mem_dest_q <= mem_dest_d;
            wb_wb_q    <= wb_wb_d;
            wb_dest_q  <= wb_dest_d;
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Outputs are gated by reset so they drop immediately, and a flush overrides freeze.
    assign flush     = rst & flush_raw;
    assign freeze    = rst & freeze_raw & ~flush_raw;
    assign fwd_sel_a = (FORWARD_EN && rst) ? fwd_a_raw : FWD_REG;
    assign fwd_sel_b = (FORWARD_EN && rst) ? fwd_b_raw : FWD_REG;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (freeze),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (branch_accept),
        .q   (flush_cnt)
    );

endmodule
